// File: rtl/sensor_acc_pkg.sv
// -----------------------------------------------------------------------------
// sensor_acc_pkg
// Shared types and helpers for the sensor accumulator:
//   deb_state_e   - debounce FSM state encoding
//   hex_to_seg7() - 4-bit value to active-low 7-segment pattern (bit6=g .. bit0=a)
// -----------------------------------------------------------------------------
package sensor_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HELD      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } deb_state_e;

    // Active-low segments: a '0' lights the segment.
    function automatic logic [6:0] hex_to_seg7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/debounce_pulse.sv
// -----------------------------------------------------------------------------
// debounce_pulse
// Synchronises a raw pushbutton, debounces it with a four-state FSM and emits
// exactly one single-cycle pulse per accepted press.
// Ports:
//   clk      - clock, all state on rising edge
//   reset    - asynchronous active-high reset
//   btn_i    - raw button, asynchronous to clk
//   pulse_o  - registered one-cycle pulse when a press is accepted
// -----------------------------------------------------------------------------
module debounce_pulse
    import sensor_acc_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [1:0]       fill_q;
    logic             armed_q;
    deb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q;

    // fill_q marks when the synchroniser holds real samples again after reset.
    // armed_q only sets once a genuine low level is seen, so a button still held
    // through a reset cannot be mistaken for a new press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1] && !sync2_q)
                armed_q <= 1'b1;
            pulse_q <= 1'b0;

            // The sample that causes a state entry counts as the first of the run.
            case (state_q)
                ST_IDLE: begin
                    if (sync2_q && armed_q) begin
                        state_q <= ST_WAIT_HIGH;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!sync2_q) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!sync2_q) begin
                        state_q <= ST_WAIT_LOW;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_WAIT_LOW: begin
                    if (sync2_q) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/sensor_accumulator_n.sv
// -----------------------------------------------------------------------------
// sensor_accumulator_n
// Priority-encodes N_SENS sensor lines; each debounced press of 'enable' adds
// the encoded index to an ACC_W-bit accumulator (saturating or wrapping).
// Ports:
//   clk, reset        - clock / asynchronous active-high reset
//   enable            - raw pushbutton (asynchronous)
//   clear             - synchronous accumulator + overflow clear
//   sensores          - sensor lines
//   cod_out/cod_valid - highest active sensor index / any sensor active
//   sum_out           - value acc_out would take if a press landed now
//   acc_out, overflow - accumulator and sticky overflow flag
//   motor_on          - acc_out is odd
//   segmentos         - active-low 7-segment of acc_out[3:0]
// -----------------------------------------------------------------------------
module sensor_accumulator_n
    import sensor_acc_pkg::*;
#(
    parameter int N_SENS     = 8,
    parameter int ACC_W      = 4,
    parameter int DEB_CYCLES = 4,
    parameter int SATURATE   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [N_SENS-1:0]         sensores,
    output logic [$clog2(N_SENS)-1:0] cod_out,
    output logic                      cod_valid,
    output logic [ACC_W-1:0]          sum_out,
    output logic [ACC_W-1:0]          acc_out,
    output logic                      overflow,
    output logic                      motor_on,
    output logic [6:0]                segmentos
);

    localparam int COD_W = $clog2(N_SENS);
    // Wide enough for both operands plus carry even when the index is wider
    // than the accumulator.
    localparam int SUM_W = ((ACC_W > COD_W) ? ACC_W : COD_W) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'((1 << ACC_W) - 1);

    logic [COD_W-1:0] cod;
    logic             valid;
    logic [SUM_W-1:0] sum_wide;
    logic             ovf_evt;
    logic [ACC_W-1:0] sum_sel;
    logic             add_pulse;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    debounce_pulse #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (enable),
        .pulse_o (add_pulse)
    );

    // Ascending scan: the last (highest) active index wins.
    always_comb begin
        cod   = '0;
        valid = 1'b0;
        for (int i = 0; i < N_SENS; i++) begin
            if (sensores[i]) begin
                cod   = COD_W'(i);
                valid = 1'b1;
            end
        end
    end

    always_comb begin
        sum_wide = SUM_W'(acc_q) + SUM_W'(cod);
        ovf_evt  = (sum_wide > ACC_MAX);
        if (ovf_evt && (SATURATE != 0))
            sum_sel = ACC_MAX[ACC_W-1:0];
        else
            sum_sel = sum_wide[ACC_W-1:0];
    end

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (add_pulse && valid) begin
            acc_d = sum_sel;
            if (ovf_evt)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cod_out   = cod;
    assign cod_valid = valid;
    assign sum_out   = sum_sel;
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
    assign motor_on  = acc_q[0];
    // Narrow accumulators are zero-extended to a nibble before decoding.
    assign segmentos = hex_to_seg7(4'(acc_q));

endmodule

// File: doc/sensor_accumulator_n.md
SENSOR_ACCUMULATOR_N -- requirements
Module: sensor_accumulator_n

Interface
REQ-001 Parameter N_SENS, default 8, number of sensor inputs (2..16).
REQ-002 Parameter ACC_W, default 4, accumulator width (2..8).
REQ-003 Parameter DEB_CYCLES, default 4, consecutive stable samples needed to accept a press (2..2^16).
REQ-004 Parameter SATURATE, default 1, 1 = clamp at maximum, 0 = wrap modulo 2^ACC_W.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  raw pushbutton, asynchronous to clk, active-high.
REQ-008 clear  input  1  synchronous accumulator clear, active-high.
REQ-009 sensores  input  N_SENS  sensor lines, active-high.
REQ-010 cod_out  output  $clog2(N_SENS)  priority-encoded sensor index.
REQ-011 cod_valid  output  1  at least one sensor active.
REQ-012 sum_out  output  ACC_W  next accumulator value if a press were accepted now.
REQ-013 acc_out  output  ACC_W  registered accumulator.
REQ-014 overflow  output  1  sticky overflow flag.
REQ-015 motor_on  output  1  motor drive.
REQ-016 segmentos  output  7  active-low hex of acc_out[3:0], bit6=g .. bit0=a.

Function
REQ-017 Encoder: cod_out = highest set index of sensores; all zero -> cod_out=0, cod_valid=0; combinational.
REQ-018 enable shall pass through a 2-flop synchronizer before any use.
REQ-019 Debounce FSM states IDLE, WAIT_HIGH, HELD, WAIT_LOW; IDLE->WAIT_HIGH on sync=1.
REQ-020 WAIT_HIGH: sync=0 -> IDLE; DEB_CYCLES consecutive sync=1 samples -> HELD, issuing a one-cycle add pulse.
REQ-021 HELD: sync=0 -> WAIT_LOW; WAIT_LOW: sync=1 -> HELD; DEB_CYCLES consecutive sync=0 samples -> IDLE.
REQ-022 Exactly one add pulse per accepted press regardless of hold length.
REQ-023 acc_out updates on the rising edge terminating the add pulse; latency from a clean raw rising edge to acc_out change = DEB_CYCLES+3 clk edges.
REQ-024 Add pulse with cod_valid=0 shall leave acc_out unchanged.
REQ-025 Add arithmetic ACC_W+1 bits wide; carry out or result >2^ACC_W-1 is an overflow event.
REQ-026 SATURATE=1: overflow event -> acc_out = 2^ACC_W-1; SATURATE=0: acc_out = low ACC_W bits of the sum.
REQ-027 overflow sets on any overflow event; cleared only by clear or reset.
REQ-028 sum_out = acc_out + cod_out with the same SATURATE rule, combinational.
REQ-029 clear zeroes acc_out and overflow next edge; clear wins over a simultaneous add pulse.
REQ-030 motor_on = acc_out[0] (odd values); combinational from acc_out.
REQ-031 segmentos: hex 0-F of acc_out[3:0]; for ACC_W<4 upper nibble bits zero-extended.

Reset
REQ-032 Reset shall force acc_out=0, overflow=0, FSM=IDLE, debounce counter=0, synchronizer flops=0, hence motor_on=0, segmentos=7'h40.
REQ-033 Reset mid-debounce (any state) shall abort the press; no add pulse until a fresh full press after release.

Structure
REQ-034 Package sensor_acc_pkg shall hold the FSM state enum and the hex-to-7-segment function.
REQ-035 Debouncer (synchronizer, FSM, counter, pulse) shall be sub-module debounce_pulse; encoder, adder, register and decoders stay in the top.

Verification
REQ-036 Defaults; assert reset -> acc_out=0, overflow=0, motor_on=0, segmentos=7'h40.
REQ-037 sensores=8'b0010_0100, enable held high 20 cycles -> cod_out=5, exactly one add at edge 7, acc_out=5, motor_on=1, segmentos=7'h12.
REQ-038 enable toggling every 2 cycles for 16 cycles, then low -> no add, acc_out unchanged.
REQ-039 SATURATE=1, acc_out=12, cod_out=7, one press -> acc_out=15, overflow=1; second press -> still 15.
REQ-040 SATURATE=0, acc_out=14, cod_out=3, one press -> acc_out=1, overflow=1; sum_out=1 before the press.
REQ-041 clear asserted in the add-pulse cycle -> acc_out=0, overflow=0; reset pulsed in WAIT_HIGH -> no add after release.
